// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte handshake between upstream logic and the UART transmitter
interface uart_transmitter_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    modport master (output i_data, output i_valid, input o_ready);
    modport slave (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART serialiser with valid/ready byte input; define UART_TX_PARITY_EN to add an even parity bit
module uart_transmitter #(
    parameter int CYCLES_PER_BIT = 22274,
    parameter int DATA_BITS      = 8
) (
    input  logic              clk,
    input  logic              i_reset_n,
    uart_transmitter_if.slave bus,
    output logic              o_tx,
    output logic              o_busy
);
    localparam int CW = $clog2(CYCLES_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [2:0]           idx, idx_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic                 tx_d;
    logic                 tc;

    assign tc          = cnt == CW'(CYCLES_PER_BIT - 1);
    assign bus.o_ready = state == ST_IDLE;
    assign o_busy      = state != ST_IDLE;

    // state, bit timer, shift register and the registered line
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            o_tx  <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shift <= shift_d;
            o_tx  <= tx_d;
        end
    end

    // next bit is chosen on the terminal-count edge so each bit lasts exactly CYCLES_PER_BIT cycles
    always_comb begin
        state_d = state;
        idx_d   = idx;
        shift_d = shift;
        tx_d    = o_tx;
        cnt_d   = (state == ST_IDLE || tc) ? '0 : cnt + CW'(1);
        case (state)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    state_d = ST_START;
                    shift_d = bus.i_data;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tc) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift[0];
                end
            end
            ST_DATA: begin
                if (tc && idx == 3'(DATA_BITS - 1)) begin
                    idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                    state_d = ST_PARITY;
                    tx_d    = ^shift;
`else
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
`endif
                end else if (tc) begin
                    idx_d = idx + 3'd1;
                    tx_d  = shift[idx + 3'd1];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tc) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tc) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of framing, timing, handshake and reset of uart_transmitter
module tb_uart_transmitter;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif

    logic clk = 1'b0;
    logic i_reset_n = 1'b0;
    logic o_tx;
    logic o_busy;
    int   checks = 0;
    int   errors = 0;

    uart_transmitter_if bus();

    uart_transmitter #(.CYCLES_PER_BIT(CPB)) dut (
        .clk(clk),
        .i_reset_n(i_reset_n),
        .bus(bus),
        .o_tx(o_tx),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NSLOT-1:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    task automatic start_frame(input logic [7:0] d, input logic hold);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        @(posedge clk);
        #1;
        bus.i_valid = hold;
    endtask

    task automatic capture_frame(input logic [7:0] d, input int pulse_at, input string tag);
        logic [NSLOT-1:0] rx;
        logic stable;
        logic busy_all;
        rx = '0;
        stable = 1'b1;
        busy_all = 1'b1;
        for (int s = 0; s < NSLOT; s++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (c == 0) rx[s] = o_tx;
                else if (o_tx !== rx[s]) stable = 1'b0;
                if (bus.o_ready !== 1'b0 || o_busy !== 1'b1) busy_all = 1'b0;
                if (s * CPB + c == pulse_at) begin
                    bus.i_valid = 1'b1;
                    bus.i_data  = 8'hFF;
                end
                if (s * CPB + c == pulse_at + 2) bus.i_valid = 1'b0;
            end
        end
        check({tag, "_bits"}, 32'(rx), 32'(exp_frame(d)));
        check({tag, "_stable"}, 32'(stable), 32'd1);
        check({tag, "_busy"}, 32'(busy_all), 32'd1);
        @(negedge clk);
        check({tag, "_ready_back"}, 32'(bus.o_ready), 32'd1);
        check({tag, "_idle_line"}, 32'(o_tx), 32'd1);
    endtask

    task automatic check_idle(input int n, input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || bus.o_ready !== 1'b1 || o_busy !== 1'b0) ok = 1'b0;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_reset_n = 1'b1;
        @(negedge clk);

        start_frame(8'h55, 1'b0);
        capture_frame(8'h55, -10, "f55");

        start_frame(8'hA3, 1'b1);
        bus.i_data = 8'h0F;
        capture_frame(8'hA3, -10, "b2b_a3");
        start_frame(8'h0F, 1'b0);
        capture_frame(8'h0F, -10, "b2b_0f");

        start_frame(8'h3C, 1'b0);
        capture_frame(8'h3C, 5, "ign");
        check_idle(2 * CPB, "ign_no_extra");

        start_frame(8'h07, 1'b0);
        capture_frame(8'h07, -10, "f07");
        start_frame(8'h03, 1'b0);
        capture_frame(8'h03, -10, "f03");

        start_frame(8'h00, 1'b0);
        repeat (4 * CPB + 2) @(negedge clk);
        check("mid_bit3_low", 32'(o_tx), 32'd0);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(o_tx), 32'd1);
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        i_reset_n = 1'b1;
        check_idle(3 * CPB, "mid_rst_quiet");

        start_frame(8'hC6, 1'b0);
        capture_frame(8'hC6, -10, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serialises one byte per transaction onto a single UART TX line using 8N1 framing: start bit, 8 data bits LSB first, stop bit.
- It is the transmit-side counterpart of the UART receiver and shares its bit-timing parameter, so that a loopback of TX to RX round-trips the data.
- A simple valid/ready handshake accepts bytes from upstream logic; the line idles high between frames.

Parameters:
- CYCLES_PER_BIT, 22274, clock cycles each bit is held on the line (integer, ≥2, <65536).
- DATA_BITS, 8, data bits per frame (fixed at 8; exposed for readability only, other values unsupported).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_data  input  8  byte to send; sampled only in the accept cycle.
- i_valid  input  1  upstream has a byte on i_data.
- o_ready  output  1  block can accept a byte this cycle.
- o_tx  output  1  serial line; registered, glitch-free.
- o_busy  output  1  a frame is in progress (the inverse of o_ready).

Behaviour:
- Reset: asserting i_reset_n=0 immediately (asynchronously) forces:
  - state=IDLE, o_tx=1, o_ready=1, o_busy=0;
  - cycle counter=0, bit index=0, shift register=0.
  - Deassertion takes effect on the next posedge.
- Reset mid-frame:
  - The frame is abandoned and the line returns high at once; no stop bit is completed.
  - The byte is lost, and no partial resume occurs after reset.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- Accept:
  - A byte is accepted when i_valid=1 and o_ready=1 at a posedge.
  - On that edge: i_data is loaded into the shift register, state→START_BIT, o_tx→0, o_ready→0, counter=0.
  - i_valid while o_ready=0 is ignored (no queuing); upstream must hold i_valid until o_ready.
  - Changes to i_data after the accept edge have no effect on the current frame.
- Latency: o_tx falls on the same edge that accepts the byte, i.e. 1 cycle after i_valid is seen high with o_ready.
- Bit timing:
  - Each bit (start, each data bit, stop) is held on o_tx for exactly CYCLES_PER_BIT cycles.
  - The counter counts 0..CYCLES_PER_BIT-1; at terminal count it resets to 0 and the next bit is driven on that same edge.
- Per-state transitions:
  - START_BIT: o_tx=0. At terminal count → DATA_BITS, o_tx=shift[0], bit index=0.
  - DATA_BITS: o_tx=shift[bit index].
    - At terminal count with bit index<7: index+1 and drive the next bit.
    - At terminal count with index=7: → STOP_BIT, o_tx=1, index=0.
  - STOP_BIT: o_tx=1. At terminal count → IDLE, o_ready=1, o_busy=0.
- Frame length: 10×CYCLES_PER_BIT cycles from the accept edge to the return of o_ready.
- Back-to-back:
  - o_ready is high for at least one full cycle between frames, so the minimum inter-frame gap is 0 extra idle bit-times beyond the stop bit.
  - If i_valid is already high when o_ready returns, the next start bit begins on the following edge.
  - The stop bit is therefore never shortened.
- Widths:
  - The counter is $clog2(CYCLES_PER_BIT) bits wide, with no overflow possible.
  - The bit index is 3 bits wide.
- Outputs: o_ready and o_busy are derived from registered state, never combinationally from i_valid.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - A PARITY_BIT state is inserted between DATA_BITS and STOP_BIT.
  - o_tx carries even parity (XOR of the 8 data bits) for CYCLES_PER_BIT cycles.
  - Frame length becomes 11×CYCLES_PER_BIT.
- UART_TX_PARITY_EN undefined:
  - No parity state exists in the RTL.
  - The frame is 8N1, 10×CYCLES_PER_BIT long.

Test Plan:
- Reset: hold i_reset_n=0 for 3 cycles → o_tx=1, o_ready=1, o_busy=0; drop reset mid-cycle → outputs change without waiting for clk.
- Single frame, CYCLES_PER_BIT=4, send 0x55 → o_tx sequence per 4-cycle slot is 0,1,0,1,0,1,0,1,0,1; o_ready returns exactly 40 cycles after the accept edge.
- Back-to-back 0xA3 then 0x0F with i_valid held high → second start bit starts 1 cycle after o_ready pulses high; both bytes decode correctly via loopback into uart_receiver.
- Ignored request: pulse i_valid with i_data=0xFF while o_busy=1 → current frame unchanged; no extra frame is sent afterwards.
- Reset mid-frame: assert i_reset_n=0 during data bit 3 of 0x00 → o_tx=1 immediately; after release, o_ready=1 and the line stays high with no residual bits.
- With UART_TX_PARITY_EN and CYCLES_PER_BIT=4, send 0x07 → parity slot=1, frame length 44 cycles; send 0x03 → parity slot=0.
